// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: assembles RV32I instruction fields into 32-bit words
// and writes them sequentially into instruction memory (bench/boot loader).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clear             sync restart at BASE_ADDR, counters zeroed
//   in_valid/in_ready input handshake (in_ready is combinational)
//   fmt, opcode, func3, func7, rd, rs1, rs2, imm   instruction fields
//   imem_we/addr/wdata registered memory write port
//   count, full       legal instructions written, full flag
//   err, err_cnt      sticky reject flag, saturating reject count
module instr_encoder_loader #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [2:0]        func3,
   input  logic [6:0]        func7,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err,
   output logic [7:0]        err_cnt
);

   localparam int unsigned        CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0]  BASE_C  = ADDR_W'(BASE_ADDR);
   localparam logic [6:0]         OP_IMM  = 7'b0010011;

   logic signed [31:0] simm;
   logic [31:0]        word_c;
   logic               legal_c;
   logic               is_shift_c;
   logic               accept_c;
   logic [CNT_W-1:0]   count_inc_c;

   assign simm        = $signed(imm);
   assign in_ready    = (count < DEPTH_C) && !clear;
   assign accept_c    = in_valid && in_ready;
   assign count_inc_c = count + CNT_W'(1);

   // Only OP-IMM shifts carry func7/shamt; loads with func3 001/101 are plain I-type.
   assign is_shift_c = (opcode == OP_IMM) && ((func3 == 3'b001) || (func3 == 3'b101));

   // Field assembly and immediate range check for the presented instruction.
   always_comb begin
      word_c  = '0;
      legal_c = 1'b0;
      unique case (fmt)
         3'd0: begin
            word_c  = {func7, rs2, rs1, func3, rd, opcode};
            legal_c = 1'b1;
         end
         3'd1: begin
            if (is_shift_c) begin
               word_c  = {func7, imm[4:0], rs1, func3, rd, opcode};
               legal_c = (simm >= 32'sd0) && (simm <= 32'sd31);
            end else begin
               word_c  = {imm[11:0], rs1, func3, rd, opcode};
               legal_c = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
         end
         3'd2: begin
            word_c  = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            legal_c = (simm >= -32'sd2048) && (simm <= 32'sd2047);
         end
         3'd3: begin
            word_c  = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            legal_c = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
         end
         3'd4: begin
            word_c  = {imm[31:12], rd, opcode};
            legal_c = (imm[11:0] == 12'd0);
         end
         3'd5: begin
            word_c  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            legal_c = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
         end
         default: begin
            word_c  = '0;
            legal_c = 1'b0;
         end
      endcase
   end

   // Write port, counters and error tracking; clear outranks any accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_we    <= 1'b0;
         imem_addr  <= BASE_C;
         imem_wdata <= '0;
         count      <= '0;
         full       <= 1'b0;
         err        <= 1'b0;
         err_cnt    <= '0;
      end else if (clear) begin
         imem_we    <= 1'b0;
         imem_addr  <= BASE_C;
         imem_wdata <= '0;
         count      <= '0;
         full       <= 1'b0;
         err        <= 1'b0;
         err_cnt    <= '0;
      end else begin
         imem_we <= 1'b0;
         if (accept_c) begin
            if (legal_c) begin
               imem_we    <= 1'b1;
               // count equals writes so far, so it is also the next slot offset.
               imem_addr  <= BASE_C + count[ADDR_W-1:0];
               imem_wdata <= word_c;
               count      <= count_inc_c;
               full       <= (count_inc_c == DEPTH_C);
            end else begin
               err <= 1'b1;
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
         end
      end
   end

endmodule
